// File: rtl/reg_file_pkg.sv
// Shared CPU package: datapath widths and architectural constants used by
// the register file, the alu and the decoder.
package reg_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int unsigned REG_ZERO = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Two-read/one-write register file with hardwired-zero register 0,
// combinational reads and same-cycle write-to-read bypass on both ports.
module reg_file #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r_addr1,
  input  logic [ADDR_W-1:0] r_addr2,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data1,
  output logic [DATA_W-1:0] r_data2
);

  import reg_file_pkg::*;

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              wr_live_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;

  // A write is only live outside reset and never towards the zero register;
  // the same qualifier gates both the storage update and the bypass.
  assign wr_live_s = w_en && !rst && (w_addr != ZERO_ADDR);

  // Storage: single-cycle clear on reset, otherwise one qualified write per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_live_s) begin
      regs_r[w_addr] <= w_data;
    end
  end

  // Read port 1: stored value, overridden by the in-flight write on a hit.
  always_comb begin
    rd1_s = regs_r[r_addr1];
    if (wr_live_s && (r_addr1 == w_addr)) begin
      rd1_s = w_data;
    end else begin
      rd1_s = regs_r[r_addr1];
    end
  end

  // Read port 2: independent copy of the same bypass comparator.
  always_comb begin
    rd2_s = regs_r[r_addr2];
    if (wr_live_s && (r_addr2 == w_addr)) begin
      rd2_s = w_data;
    end else begin
      rd2_s = regs_r[r_addr2];
    end
  end

  assign r_data1 = rd1_s;
  assign r_data2 = rd2_s;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the driver queues expected read data per
// cycle, a negedge monitor pops and compares against both read ports.
module tb_reg_file;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
    bit          alu;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  r_addr1 = 5'd0;
  logic [4:0]  r_addr2 = 5'd0;
  logic        w_en = 1'b0;
  logic [4:0]  w_addr = 5'd0;
  logic [31:0] w_data = 32'h0;
  logic [31:0] r_data1;
  logic [31:0] r_data2;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .r_addr1 (r_addr1),
    .r_addr2 (r_addr2),
    .w_en    (w_en),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .r_data1 (r_data1),
    .r_data2 (r_data2)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the rising edge; optionally queue expectations.
  task automatic cyc(input logic r, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] a1,
                     input logic [4:0] a2, input bit chk,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input string nm, input bit alu);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; w_en = we; w_addr = wa; w_data = wd; r_addr1 = a1; r_addr2 = a2;
    if (chk) begin
      e.name = nm; e.e1 = e1; e.e2 = e2; e.alu = alu;
      sb.push_back(e);
    end
  endtask

  // Monitor: mid-cycle, compare both read ports against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] sum;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (r_data1 !== e.e1) begin
        miscompares++;
        $display("FAIL %s port1: got %08h expected %08h", e.name, r_data1, e.e1);
      end
      vectors++;
      if (r_data2 !== e.e2) begin
        miscompares++;
        $display("FAIL %s port2: got %08h expected %08h", e.name, r_data2, e.e2);
      end
      if (e.alu) begin
        sum = r_data1 + r_data2;
        vectors++;
        if (sum !== 32'd2 || sum == 32'd0) begin
          miscompares++;
          $display("FAIL %s alu_add: got %08h expected %08h", e.name, sum, 32'd2);
        end
      end
    end
  end

  initial begin
    // Reset, and reads while reset is held.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "rst0", 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b1, 32'h0, 32'h0, "rst_held", 1'b0);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, 32'h0, 32'h0,
          $sformatf("post_rst_%0d", i), 1'b0);
    end

    // Reg1 = reg2 = 1, then alu add of both ports.
    cyc(1'b0, 1'b1, 5'd1, 32'h1, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "wr_r1", 1'b0);
    cyc(1'b0, 1'b1, 5'd2, 32'h1, 5'd1, 5'd2, 1'b1, 32'h1, 32'h1, "wr_r2_byp", 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, 32'h1, 32'h1, "rd_r1_r2", 1'b1);

    // Writes to reg 0 are discarded and never bypassed.
    cyc(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "wr_r0", 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, "rd_r0", 1'b0);

    // Bypass on both ports, then hold with w_en low and junk on w_addr/w_data.
    cyc(1'b0, 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5, 1'b1, 32'h12345678, 32'h12345678, "byp_r5", 1'b0);
    cyc(1'b0, 1'b0, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5, 1'b1, 32'h12345678, 32'h12345678, "hold_r5", 1'b0);
    cyc(1'b0, 1'b0, 5'd5, 32'hCAFEF00D, 5'd5, 5'd1, 1'b1, 32'h12345678, 32'h1, "hold_r5b", 1'b0);

    // Write during reset is dropped and not bypassed; reset clears everything.
    cyc(1'b0, 1'b1, 5'd3, 32'h7FFFFFFF, 5'd3, 5'd3, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, "wr_r3", 1'b0);
    cyc(1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, "rst_wr_r3", 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 32'h0, 32'h0, "r3_cleared", 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd1, 1'b1, 32'h0, 32'h0, "r5_r1_cleared", 1'b0);

    // Back-to-back writes to reg 4.
    cyc(1'b0, 1'b1, 5'd4, 32'hA, 5'd4, 5'd4, 1'b1, 32'hA, 32'hA, "b2b_a", 1'b0);
    cyc(1'b0, 1'b1, 5'd4, 32'hB, 5'd4, 5'd4, 1'b1, 32'hB, 32'hB, "b2b_b", 1'b0);
    cyc(1'b0, 1'b1, 5'd4, 32'hC, 5'd4, 5'd4, 1'b1, 32'hC, 32'hC, "b2b_c", 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 32'hC, 32'hC, "b2b_final", 1'b0);

    // Full-width storage and port independence under bypass.
    cyc(1'b0, 1'b1, 5'd7, 32'h80000000, 5'd0, 5'd4, 1'b1, 32'h0, 32'hC, "wr_r7", 1'b0);
    cyc(1'b0, 1'b1, 5'd6, 32'h5A5AA5A5, 5'd6, 5'd7, 1'b1, 32'h5A5AA5A5, 32'h80000000, "byp_p1_only", 1'b0);
    cyc(1'b0, 1'b1, 5'd31, 32'hFFFF0000, 5'd6, 5'd31, 1'b1, 32'h5A5AA5A5, 32'hFFFF0000, "byp_p2_only", 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd7, 1'b1, 32'hFFFF0000, 32'h80000000, "rd_r31_r7", 1'b0);

    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "idle", 1'b0);
    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width (2**ADDR_W registers).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 r_addr1  input  ADDR_W  SHALL select the register driven on r_data1.
REQ-006 r_addr2  input  ADDR_W  SHALL select the register driven on r_data2.
REQ-007 w_en  input  1  SHALL qualify a write in the current cycle.
REQ-008 w_addr  input  ADDR_W  SHALL select the register written when w_en=1.
REQ-009 w_data  input  DATA_W  SHALL be the write value.
REQ-010 r_data1  output  DATA_W  SHALL be read port 1, feeding ALU oper1.
REQ-011 r_data2  output  DATA_W  SHALL be read port 2, feeding ALU oper2.

Function
REQ-012 Storage SHALL be 2**ADDR_W registers of DATA_W bits, updated only on the rising edge of clk.
REQ-013 A write SHALL occur on a rising edge when w_en=1, rst=0 and w_addr!=0; the new value is visible on reads from the following cycle.
REQ-014 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded with no side effect.
REQ-015 Reads SHALL be combinational, with zero-cycle latency from r_addrN to r_dataN.
REQ-016 Same-cycle bypass: when w_en=1, rst=0, w_addr!=0 and r_addrN==w_addr, r_dataN SHALL equal w_data in that same cycle.
REQ-017 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data, including under bypass.
REQ-018 w_data SHALL be stored unmodified at full DATA_W width, with no sign or zero extension.
REQ-019 With w_en=0, storage SHALL hold its value indefinitely, and w_addr and w_data SHALL be ignored.
REQ-020 Back-to-back writes to the same address SHALL leave the last-written value; each intermediate value SHALL be readable in the cycle after its write.

Reset
REQ-021 On a rising edge with rst=1, every register SHALL be cleared to 0 in that single cycle.
REQ-022 A write presented while rst=1 SHALL be discarded, and bypass SHALL be suppressed, so reads return stored (cleared) data.
REQ-023 During and after reset, r_data1 and r_data2 SHALL read 0 for every address until the next write.
REQ-024 Asserting reset between two writes SHALL erase the first write, so only writes after reset deassertion persist.

Structure
REQ-025 DATA_W, ADDR_W and the constant REG_ZERO (=0) SHALL live in the shared CPU package used by the alu and the decoder.
REQ-026 The block SHALL be a single module with no sub-module; the bypass comparator SHALL be duplicated inline, once per read port.
REQ-027 Storage SHALL be inferred as a flop array, not vendor RAM, so that single-cycle clear and zero-latency reads hold.

Verification
REQ-028 Reset, then read all 32 addresses on both ports -> every read returns 0x00000000.
REQ-029 Write 0x00000001 to reg 1 and to reg 2, then read r_addr1=1, r_addr2=2 -> r_data1=r_data2=0x00000001; the attached alu with control=0 returns result=2, zero=0, overflow=0.
REQ-030 Write 0xDEADBEEF to reg 0, then read reg 0 on both ports -> 0x00000000 in the write cycle and in all later cycles.
REQ-031 In one cycle set w_en=1, w_addr=5, w_data=0x12345678, r_addr1=5, r_addr2=5 -> both ports read 0x12345678 in that cycle; reg 5 holds it in the next cycle.
REQ-032 Write 0x7FFFFFFF to reg 3, assert rst for one cycle while also writing 0xFFFFFFFF to reg 3 -> reg 3 reads 0 after the reset cycle.
REQ-033 Write reg 4 with 0xA, then 0xB, then 0xC on consecutive cycles while reading reg 4 -> the bypass shows 0xA, 0xB, 0xC each cycle, and the final stored value is 0xC.
